// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Registered, flow-controlled demultiplexer. Each input word is routed to one
// of 2**ADDRESS_WIDTH output channels, selected by the address that travels
// with it. Every channel owns a one-entry output slot with its own
// valid/ready handshake. A stalled consumer therefore only blocks words
// addressed to its own channel.
//
// Optional feature macro: DEMUX_BROADCAST_EN
//   When defined, the i_bcast port exists. With i_bcast high, a word is
//   accepted only when every slot is free, and it is then loaded into all
//   slots on the same edge. When undefined, routing is unicast only.
//
// Parameters:
//   ADDRESS_WIDTH - address bits; the channel count is 2**ADDRESS_WIDTH
//   DATA_WIDTH    - bits per word
//
// Ports:
//   i_clk    - clock; all state updates on the rising edge
//   i_rst_n  - asynchronous active-low reset; empties every slot
//   i_valid  - input word present
//   o_ready  - input word accepted when i_valid && o_ready
//   i_add    - destination channel of the input word
//   i_data   - input word
//   i_bcast  - broadcast request (DEMUX_BROADCAST_EN builds only)
//   o_valid  - bit k: channel k holds a word
//   i_ready  - bit k: consumer k takes the word this cycle
//   o_data   - channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter int ADDRESS_WIDTH = 2,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_valid,
    output logic                                      o_ready,
    input  logic [ADDRESS_WIDTH-1:0]                  i_add,
    input  logic [DATA_WIDTH-1:0]                     i_data,
`ifdef DEMUX_BROADCAST_EN
    input  logic                                      i_bcast,
`endif
    output logic [(2**ADDRESS_WIDTH)-1:0]             o_valid,
    input  logic [(2**ADDRESS_WIDTH)-1:0]             i_ready,
    output logic [(2**ADDRESS_WIDTH)*DATA_WIDTH-1:0]  o_data
);

    localparam int NUM_CH = 2**ADDRESS_WIDTH;

    logic [NUM_CH-1:0]     full_q;
    logic [NUM_CH-1:0]     full_d;
    logic [DATA_WIDTH-1:0] data_q [NUM_CH];
    logic [DATA_WIDTH-1:0] data_d [NUM_CH];

    logic [NUM_CH-1:0]     drain_s;
    logic [NUM_CH-1:0]     free_s;
    logic [NUM_CH-1:0]     load_s;
    logic                  ready_s;

    // A slot is free when empty or when its consumer empties it this cycle;
    // the second case gives full throughput through a busy channel.
    always_comb begin
        drain_s = full_q & i_ready;
        free_s  = ~full_q | drain_s;
    end

    // Input readiness depends only on the address, the slot state and the
    // consumer readies, never on i_valid.
    always_comb begin
        ready_s = 1'b0;
`ifdef DEMUX_BROADCAST_EN
        if (i_bcast) begin
            ready_s = &free_s;
        end else begin
            ready_s = free_s[i_add];
        end
`else
        ready_s = free_s[i_add];
`endif
    end

    // Select which slots capture the input word on this edge.
    always_comb begin
        load_s = {NUM_CH{1'b0}};
        if (i_valid && ready_s) begin
`ifdef DEMUX_BROADCAST_EN
            if (i_bcast) begin
                load_s = {NUM_CH{1'b1}};
            end else begin
                load_s[i_add] = 1'b1;
            end
`else
            load_s[i_add] = 1'b1;
`endif
        end else begin
            load_s = {NUM_CH{1'b0}};
        end
    end

    // Slot next state: a load wins over a drain, so a slot that is drained and
    // reloaded in the same cycle stays full with the new word. A drain alone
    // clears the full flag and leaves the stale data in place.
    always_comb begin
        full_d = full_q;
        for (int k = 0; k < NUM_CH; k++) begin
            data_d[k] = data_q[k];
            if (load_s[k]) begin
                full_d[k] = 1'b1;
                data_d[k] = i_data;
            end else if (drain_s[k]) begin
                full_d[k] = 1'b0;
                data_d[k] = data_q[k];
            end else begin
                full_d[k] = full_q[k];
                data_d[k] = data_q[k];
            end
        end
    end

    // Slot registers; reset discards every held word at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q <= {NUM_CH{1'b0}};
            for (int k = 0; k < NUM_CH; k++) begin
                data_q[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            full_q <= full_d;
            for (int k = 0; k < NUM_CH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign o_ready = ready_s;
    assign o_valid = full_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign o_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
    end

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//
// Self-checking bench for stream_demux with ADDRESS_WIDTH = 2 and
// DATA_WIDTH = 8. A table of single-cycle vectors covers unicast routing,
// back-pressure isolation and pass-through. Hand-written sequences cover
// streaming, asynchronous reset mid-stream and, in DEMUX_BROADCAST_EN
// builds, broadcast.
// -----------------------------------------------------------------------------
module tb_stream_demux;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  in_add;
    logic [7:0]  in_data;
    logic        in_bcast;
    logic [3:0]  out_valid;
    logic [3:0]  in_ready;
    logic [31:0] out_data;

    int tests;
    int fails;

    stream_demux #(
        .ADDRESS_WIDTH(2),
        .DATA_WIDTH   (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_add   (in_add),
        .i_data  (in_data),
`ifdef DEMUX_BROADCAST_EN
        .i_bcast (in_bcast),
`endif
        .o_valid (out_valid),
        .i_ready (in_ready),
        .o_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic [1:0]  add;
        logic [7:0]  data;
        logic [3:0]  rdy;
        logic        exp_ordy;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [0:8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle: check o_ready before the edge, outputs after it.
    task automatic step(input string name, input logic v, input logic [1:0] a,
                        input logic [7:0] d, input logic [3:0] r,
                        input logic e_rdy, input logic [3:0] e_vld,
                        input logic [31:0] e_dat);
        in_valid = v;
        in_add   = a;
        in_data  = d;
        in_ready = r;
        #1;
        chk({name, " o_ready"}, {31'd0, out_ready}, {31'd0, e_rdy});
        @(posedge clk);
        #1;
        chk({name, " o_valid"}, {28'd0, out_valid}, {28'd0, e_vld});
        chk({name, " o_data"}, out_data, e_dat);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_add   = 2'd0;
        in_data  = 8'h00;
        in_bcast = 1'b0;
        in_ready = 4'b0000;

        //            valid add    data   rdy      ordy  valid    data
        vecs[0] = '{1'b1, 2'd1, 8'hA5, 4'b0000, 1'b1, 4'b0010, 32'h0000A500}; // route to 1
        vecs[1] = '{1'b1, 2'd3, 8'h3C, 4'b0000, 1'b1, 4'b1010, 32'h3C00A500}; // route to 3
        vecs[2] = '{1'b1, 2'd1, 8'h77, 4'b0000, 1'b0, 4'b1010, 32'h3C00A500}; // ch1 stalled
        vecs[3] = '{1'b1, 2'd0, 8'h5A, 4'b0000, 1'b1, 4'b1011, 32'h3C00A55A}; // ch0 still free
        vecs[4] = '{1'b0, 2'd0, 8'hEE, 4'b1000, 1'b0, 4'b0011, 32'h3C00A55A}; // drain ch3 only
        vecs[5] = '{1'b1, 2'd2, 8'hC3, 4'b0000, 1'b1, 4'b0111, 32'h3CC3A55A}; // fill ch2
        vecs[6] = '{1'b1, 2'd2, 8'h11, 4'b0100, 1'b1, 4'b0111, 32'h3C11A55A}; // pass-through
        vecs[7] = '{1'b0, 2'd1, 8'h99, 4'b0000, 1'b0, 4'b0111, 32'h3C11A55A}; // idle, no change
        vecs[8] = '{1'b0, 2'd2, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h3C11A55A}; // drain all, data held

        // Reset state, before any clock edge.
        #2;
        chk("reset o_valid", {28'd0, out_valid}, 32'd0);
        chk("reset o_data", out_data, 32'd0);
        chk("reset o_ready", {31'd0, out_ready}, 32'd1);
        #5;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].add, vecs[i].data,
                 vecs[i].rdy, vecs[i].exp_ordy, vecs[i].exp_valid, vecs[i].exp_data);
        end

        // Stream 8 words through channel 2 with its consumer always ready:
        // each edge must hand over the next word in order.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'h20 + 8'(i);
            in_valid = 1'b1;
            in_add   = 2'd2;
            in_data  = w;
            in_ready = 4'b0100;
            #1;
            chk($sformatf("stream%0d o_ready", i), {31'd0, out_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d valid2", i), {31'd0, out_valid[2]}, 32'd1);
            chk($sformatf("stream%0d slice2", i), {24'd0, out_data[23:16]}, {24'd0, w});
        end
        step("stream drain", 1'b0, 2'd2, 8'h00, 4'b0100, 1'b1, 4'b0000, 32'h3C27A55A);

        // Asynchronous reset mid-stream with channel 2 full.
        step("pre-reset load", 1'b1, 2'd2, 8'h99, 4'b0000, 1'b1, 4'b0100, 32'h3C99A55A);
        in_valid = 1'b0;
        in_ready = 4'b0000;
        in_add   = 2'd2;
        rst_n    = 1'b0;
        #1;
        chk("async reset o_valid", {28'd0, out_valid}, 32'd0);
        chk("async reset o_data", out_data, 32'd0);
        chk("async reset o_ready", {31'd0, out_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        step("post-reset accept", 1'b1, 2'd1, 8'h42, 4'b0000, 1'b1, 4'b0010, 32'h00004200);

`ifdef DEMUX_BROADCAST_EN
        // Broadcast waits for every slot, then fills all of them.
        step("bcast prep", 1'b1, 2'd0, 8'h01, 4'b0010, 1'b1, 4'b0001, 32'h00004201);
        in_bcast = 1'b1;
        step("bcast stalled", 1'b1, 2'd3, 8'hFF, 4'b0000, 1'b0, 4'b0001, 32'h00004201);
        step("bcast accept", 1'b1, 2'd3, 8'hFF, 4'b0001, 1'b1, 4'b1111, 32'hFFFFFFFF);
        in_bcast = 1'b0;
        step("unicast after bcast", 1'b1, 2'd1, 8'h55, 4'b0010, 1'b1, 4'b1111, 32'hFFFF55FF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered, flow-controlled demultiplexer for the plumbing library: it routes each input word to one of 2**ADDRESS_WIDTH output channels, chosen by an address that travels with the word. Each channel has a one-entry output register with a valid/ready handshake, so a stalled channel never blocks words addressed to other channels. It is the sequential, parametrised successor of the combinational `demultiplexor`, and sits between a single producer and several independent consumers.

## Interface
- `ADDRESS_WIDTH`, default 2: address bits; channel count N = 2**ADDRESS_WIDTH.
- `DATA_WIDTH`, default 8: bits per word.
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_valid` input 1: input word present.
- `o_ready` output 1: input word accepted this cycle when `i_valid && o_ready`.
- `i_add` input ADDRESS_WIDTH: destination channel of the input word.
- `i_data` input DATA_WIDTH: input word.
- `i_bcast` input 1: broadcast request; present only with `DEMUX_BROADCAST_EN` (see Configuration).
- `o_valid` output N: bit k means channel k holds a word.
- `i_ready` input N: bit k means consumer k takes the word this cycle.
- `o_data` output N*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Channel k has a slot made of `full[k]` (drives `o_valid[k]`) and `data[k]` (drives `o_data` slice k).
- Channel k drains when `o_valid[k] && i_ready[k]`.
- Channel k is free when `!full[k]`, or when it drains in the same cycle (pass-through at full throughput).
- `o_ready` = free[`i_add`]. It is a combinational function of `i_add`, `full` and `i_ready` only; there is no combinational path from `i_valid` to `o_ready`.
- On accept:
  - `data[i_add]` <= `i_data`.
  - `full[i_add]` <= 1.
- Slot update priority for channel k when it is both draining and the accept target: the slot stays full and loads the new word.
- A channel that drains without a new load clears `full[k]`. Its `data[k]` holds the last value; consumers must qualify it with `o_valid`.
- Non-addressed channels are unaffected by accepts.
- Input words are delivered in order per channel. No ordering is guaranteed across channels.
- A word is never dropped or duplicated.
- `i_valid` low: no state change other than drains.
- `i_add` and `i_data` are don't-care while `i_valid` is low.

## Timing
- Reset (`i_rst_n` low, asynchronous): `full` = 0, `data` = 0. Outputs become `o_valid` = 0 and `o_data` = 0; `o_ready` = 1 (all slots empty).
- Reset asserted mid-operation discards all held words immediately, without waiting for a clock edge.
- Release of reset is sampled synchronously: the first accept is possible on the first rising edge with `i_rst_n` high.
- Latency: a word accepted at edge t is visible on `o_valid`/`o_data` after edge t, so it can be consumed at edge t+1.
- Throughput: one word per cycle, sustained, whenever the target consumer holds `i_ready` high.
- Full slot with its `i_ready` low: `o_ready` = 0 for words addressed there, and `o_ready` = 1 for words addressed to a free channel.

## Configuration
- `DEMUX_BROADCAST_EN` defined:
  - Port `i_bcast` exists.
  - With `i_bcast` = 1: `o_ready` = AND of free[k] over all k, and an accept loads `i_data` into every slot and sets every `full` bit in the same edge. `i_add` is ignored.
  - With `i_bcast` = 0: behaviour is identical to the undefined case.
- `DEMUX_BROADCAST_EN` undefined: port `i_bcast` is absent and broadcast logic is not compiled. Routing is unicast only.

## Test plan
Parameters for all scenarios: ADDRESS_WIDTH = 2, DATA_WIDTH = 8.
- Reset: hold `i_rst_n` = 0 mid-stream with channel 2 full -> `o_valid` = 4'b0000, `o_data` = 0 and `o_ready` = 1 immediately, before any clock edge.
- Unicast routing:
  - Stimulus: `i_add` = 1 with `i_data` = 8'hA5, then `i_add` = 3 with `i_data` = 8'h3C, one cycle each, all `i_ready` = 0.
  - Response: `o_valid` = 4'b1010, slice1 = 8'hA5, slice3 = 8'h3C, slices 0 and 2 = 0.
- Back-pressure isolation:
  - Stimulus: channel 1 full with `i_ready[1]` = 0; present `i_add` = 1, then `i_add` = 0.
  - Response: `o_ready` = 0 for the first word, `o_ready` = 1 for the second; channel 0 accepts while channel 1 keeps 8'hA5.
- Pass-through: channel 2 full, `i_ready[2]` = 1, new word 8'h11 to `i_add` = 2 in the same cycle -> `o_ready` = 1 and `o_valid[2]` stays 1 with slice2 = 8'h11 on the next cycle. Streaming 8 words with `i_ready[2]` held high -> 8 words out in 8 consecutive cycles, in order.
- Broadcast (built with `DEMUX_BROADCAST_EN`):
  - Stimulus: `i_bcast` = 1, `i_data` = 8'hFF; first with channel 0 full and `i_ready[0]` = 0, then after channel 0 drains.
  - Response: `o_ready` = 0 while channel 0 is stalled. Once it drains, the word is accepted and `o_valid` = 4'b1111 with every slice = 8'hFF.
